mem_access_arbiter: RTL and testbench

Arbitrating sequencer for the shared command memory and serial transmitter. Two command sources (port 0: host command decoder, port 1: maintenance/scan engine) issue read or write requests. The block grants one source at a time with round-robin fairness and drives the memory port. For reads it captures the memory data and hands it to the serial transmitter, with a TxDone timeout guard. It sits between the command front ends and the memory/transmitter datapath and replaces per-source ad-hoc sequencing.

---
 rtl/mem_access_arbiter_if.sv | 47 ++++
 rtl/mem_access_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_access_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_arbiter_if.sv
// Bus bundle between the two command sources, the shared command memory, the serial
// transmitter and mem_access_arbiter.
//   Req*/RW*/Addr*/WData*  : per-source request and operands (sampled at grant)
//   Gnt*/Done*/TxErr       : per-source grant, completion pulse, transmit-timeout flag
//   MemEn/MemWe/MemAddr/MemWData/MemRData : synchronous memory port
//   TxStart/TxByte/TxDone  : serial transmitter handshake
//   Busy                   : arbiter not idle
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_access_arbiter_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
);
  logic          Req0;
  logic          Req1;
  logic          RW0;
  logic          RW1;
  logic [AW-1:0] Addr0;
  logic [AW-1:0] Addr1;
  logic [DW-1:0] WData0;
  logic [DW-1:0] WData1;
  logic          Gnt0;
  logic          Gnt1;
  logic          Done0;
  logic          Done1;
  logic          TxErr;
  logic          MemEn;
  logic          MemWe;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData;
  logic [DW-1:0] MemRData;
  logic          TxStart;
  logic [DW-1:0] TxByte;
  logic          TxDone;
  logic          Busy;

  modport slave (
    input  Req0, Req1, RW0, RW1, Addr0, Addr1, WData0, WData1, MemRData, TxDone,
    output Gnt0, Gnt1, Done0, Done1, TxErr, MemEn, MemWe, MemAddr, MemWData,
           TxStart, TxByte, Busy
  );

  modport master (
    output Req0, Req1, RW0, RW1, Addr0, Addr1, WData0, WData1, MemRData, TxDone,
    input  Gnt0, Gnt1, Done0, Done1, TxErr, MemEn, MemWe, MemAddr, MemWData,
           TxStart, TxByte, Busy
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Round-robin arbitrating sequencer for the shared command memory and serial transmitter.
// One of two sources is granted at a time; writes go straight to memory, reads capture the
// memory data and hand it to the transmitter, guarded by a TxDone timeout.
// Ports:
//   Clk    : clock, rising edge
//   Reset  : asynchronous, active-high reset; aborts any access without a Done pulse
//   bus_io : source/memory/transmitter bundle (slave view of mem_access_arbiter_if)
// All outputs come straight from registers; there is no input-to-output combinational path.
module mem_access_arbiter #(
  parameter int unsigned AW         = 4,
  parameter int unsigned DW         = 8,
  parameter int unsigned TX_TIMEOUT = 255
) (
  input logic                 Clk,
  input logic                 Reset,
  mem_access_arbiter_if.slave bus_io
);

  typedef enum logic [2:0] {StIdle, StMem, StSample, StTx, StDone} state_e;

  // Last TX cycle index before the timeout fires (counter is 0 in the first TX cycle).
  localparam logic [15:0] TxLast = 16'(TX_TIMEOUT - 1);

  state_e        state_q;
  logic [1:0]    gnt_q;
  logic [1:0]    done_q;
  logic          tx_err_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic          rw_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] tx_byte_q;
  logic          tx_start_q;
  logic          busy_q;
  logic [15:0]   cnt_q;
  logic          last_q;
  logic          pick;

  // Winner: on a tie the port that was not served last; otherwise the sole requester.
  assign pick = (bus_io.Req0 && bus_io.Req1) ? ~last_q : bus_io.Req1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      tx_err_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      rw_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tx_byte_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      last_q      <= 1'b1;
    end else begin
      // Single-cycle strobes default low; each state re-asserts what it needs.
      done_q     <= 2'b00;
      tx_err_q   <= 1'b0;
      tx_start_q <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.Req0 || bus_io.Req1) begin
            state_q     <= StMem;
            gnt_q       <= pick ? 2'b10 : 2'b01;
            busy_q      <= 1'b1;
            rw_q        <= pick ? bus_io.RW1 : bus_io.RW0;
            mem_en_q    <= 1'b1;
            mem_we_q    <= pick ? bus_io.RW1 : bus_io.RW0;
            mem_addr_q  <= pick ? bus_io.Addr1 : bus_io.Addr0;
            mem_wdata_q <= pick ? bus_io.WData1 : bus_io.WData0;
          end
        end
        StMem: begin
          if (rw_q) begin
            state_q <= StDone;
            done_q  <= gnt_q;
          end else begin
            state_q <= StSample;
          end
        end
        StSample: begin
          tx_byte_q  <= bus_io.MemRData;
          tx_start_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= StTx;
        end
        StTx: begin
          // TxDone in the TxStart cycle belongs to a previous transfer and is ignored.
          // TxDone beats a simultaneous timeout.
          if ((cnt_q != '0) && bus_io.TxDone) begin
            state_q <= StDone;
            done_q  <= gnt_q;
          end else if (cnt_q == TxLast) begin
            state_q  <= StDone;
            done_q   <= gnt_q;
            tx_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          last_q  <= gnt_q[1];
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.Gnt0     = gnt_q[0];
  assign bus_io.Gnt1     = gnt_q[1];
  assign bus_io.Done0    = done_q[0];
  assign bus_io.Done1    = done_q[1];
  assign bus_io.TxErr    = tx_err_q;
  assign bus_io.MemEn    = mem_en_q;
  assign bus_io.MemWe    = mem_we_q;
  assign bus_io.MemAddr  = mem_addr_q;
  assign bus_io.MemWData = mem_wdata_q;
  assign bus_io.TxStart  = tx_start_q;
  assign bus_io.TxByte   = tx_byte_q;
  assign bus_io.Busy     = busy_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;
  localparam int unsigned AW  = 4;
  localparam int unsigned DW  = 8;
  localparam int          TXT = 8;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  mem_access_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_access_arbiter #(.AW(AW), .DW(DW), .TX_TIMEOUT(TXT)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .bus_io (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 29 + 60);
  endfunction

  // Synchronous memory device: data valid the cycle after MemEn.
  logic [7:0] mem_dev [16];
  logic [7:0] mem_q;
  assign bus.MemRData = mem_q;
  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) mem_dev[i] <= init_val(i);
      mem_q <= 8'h00;
    end else if (bus.MemEn) begin
      if (bus.MemWe) mem_dev[bus.MemAddr] <= bus.MemWData;
      mem_q <= mem_dev[bus.MemAddr];
    end
  end

  // Transaction-level reference state.
  logic [7:0] sc_mem [16];
  int         exp_last;
  logic [7:0] exp_txbyte;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) sc_mem[i] = init_val(i);
    exp_last   = 1;
    exp_txbyte = 8'h00;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {bus.Gnt1, bus.Gnt0, bus.Done1, bus.Done0, bus.TxErr, bus.MemEn,
                         bus.MemWe, bus.TxStart, bus.Busy}, 32'h0);
    chk({name, "_data"}, {bus.MemAddr, bus.MemWData, bus.TxByte}, 32'h0);
  endtask

  // Expected winner/latency/error from the arbitration and timing rules.
  task automatic predict(input logic r0, r1, rw0, rw1, input int txd0, txd1,
                         output int port, output int lat, output logic err);
    int best;
    if (r0 && r1) port = (exp_last == 1) ? 0 : 1;
    else          port = r1 ? 1 : 0;
    if (port == 1 ? rw1 : rw0) begin
      lat = 1; err = 1'b0;
    end else begin
      best = 1000;
      if (txd0 >= 1 && txd0 <= TXT - 1 && txd0 < best) best = txd0;
      if (txd1 >= 1 && txd1 <= TXT - 1 && txd1 < best) best = txd1;
      if (best != 1000) begin lat = 3 + best; err = 1'b0; end
      else              begin lat = 2 + TXT;  err = 1'b1; end
    end
  endtask

  // One arbitrated transaction; latency counted in cycles after the grant edge's MEM cycle.
  task automatic run_txn(input logic r0, r1, rw0, rw1, input logic [3:0] a0, a1,
                         input logic [7:0] d0, d1, input int txd0, txd1,
                         input int exp_port, exp_lat, input logic exp_err);
    int done_c, n_start, start_c, n_memen, bad_gnt;
    logic rw; logic [3:0] a; logic [7:0] d; logic [1:0] g;
    rw = exp_port == 1 ? rw1 : rw0;
    a  = exp_port == 1 ? a1 : a0;
    d  = exp_port == 1 ? d1 : d0;
    g  = exp_port == 1 ? 2'b10 : 2'b01;
    @(negedge Clk);
    bus.Req0 = r0; bus.Req1 = r1; bus.RW0 = rw0; bus.RW1 = rw1;
    bus.Addr0 = a0; bus.Addr1 = a1; bus.WData0 = d0; bus.WData1 = d1;
    @(posedge Clk); #1;
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    chk("mem_gnt", {bus.Gnt1, bus.Gnt0}, g);
    chk("mem_en", bus.MemEn, 1'b1);
    chk("mem_we", bus.MemWe, rw);
    chk("mem_addr", bus.MemAddr, a);
    chk("mem_wdata", bus.MemWData, d);
    chk("mem_busy", bus.Busy, 1'b1);
    done_c = -1; n_start = 0; start_c = -1; n_memen = 0; bad_gnt = 0;
    for (int c = 0; c < 300; c++) begin
      if (bus.TxStart) begin n_start++; if (start_c < 0) start_c = c; end
      if (c > 0 && bus.MemEn) n_memen++;
      if ({bus.Gnt1, bus.Gnt0} != g) bad_gnt++;
      if (bus.Done0 || bus.Done1) begin done_c = c; break; end
      bus.TxDone = (c >= 2) && ((c - 2) == txd0 || (c - 2) == txd1);
      @(posedge Clk); #1;
    end
    bus.TxDone = 1'b0;
    if (rw) sc_mem[a] = d;
    else    exp_txbyte = sc_mem[a];
    chk("latency", done_c, exp_lat);
    chk("done_port", {bus.Done1, bus.Done0}, g);
    chk("tx_err", bus.TxErr, exp_err);
    chk("tx_byte", bus.TxByte, exp_txbyte);
    chk("txstart_cnt", n_start, rw ? 0 : 1);
    if (!rw) chk("txstart_cycle", start_c, 2);
    chk("extra_memen", n_memen, 0);
    chk("gnt_stable", bad_gnt, 0);
    @(posedge Clk); #1;
    chk("idle_after", {bus.Busy, bus.Gnt1, bus.Gnt0, bus.Done1, bus.Done0}, 5'b0);
    exp_last = exp_port;
  endtask

  typedef struct {
    logic       r0, r1, rw0, rw1;
    logic [3:0] a0, a1;
    logic [7:0] d0, d1;
    int         txd0, txd1;
    int         port, lat;
    logic       err;
  } vec_t;

  vec_t tbl [11];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int port, lat, w;
    logic err, r0, r1;
    bus.Req0 = 1'b0; bus.Req1 = 1'b0; bus.RW0 = 1'b0; bus.RW1 = 1'b0;
    bus.Addr0 = '0; bus.Addr1 = '0; bus.WData0 = '0; bus.WData1 = '0; bus.TxDone = 1'b0;

    // Expected values at TX_TIMEOUT=8: write lat 1; TxDone at TX cycle t -> lat 3+t;
    // timeout -> lat 10 with error.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 8'hA5, 8'h00, -1, -1, 0, 1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h7, 8'h00, 8'h5C, -1, -1, 1, 1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h7, 8'h00, 8'h00,  5, -1, 1, 8, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 4'h2, 8'h11, 8'h22, -1, -1, 0, 1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 4'h2, 8'h11, 8'h22, -1, -1, 1, 1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 4'h2, 8'h11, 8'h22, -1, -1, 0, 1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 4'h2, 8'h11, 8'h22, -1, -1, 1, 1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 8'h00, 8'h00, -1, -1, 0, 10, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h1, 8'h00, 8'h00,  0,  3, 1, 6, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 4'h0, 8'h00, 8'h00,  7, -1, 0, 10, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 8'h00, 8'h00,  8, -1, 0, 10, 1'b1};

    // Reset state
    model_reset();
    repeat (2) @(posedge Clk);
    #1 chk_all_zero("reset");
    @(negedge Clk) Reset = 1'b0;

    // Directed vectors
    foreach (tbl[i]) begin
      run_txn(tbl[i].r0, tbl[i].r1, tbl[i].rw0, tbl[i].rw1, tbl[i].a0, tbl[i].a1,
              tbl[i].d0, tbl[i].d1, tbl[i].txd0, tbl[i].txd1, tbl[i].port, tbl[i].lat,
              tbl[i].err);
    end

    // Both requests held: back-to-back writes every 3 cycles, alternating grants.
    w = (exp_last == 1) ? 0 : 1;
    @(negedge Clk);
    bus.Req0 = 1'b1; bus.Req1 = 1'b1; bus.RW0 = 1'b1; bus.RW1 = 1'b1;
    bus.Addr0 = 4'h4; bus.Addr1 = 4'h5; bus.WData0 = 8'h44; bus.WData1 = 8'h55;
    for (int c = 0; c < 12; c++) begin
      @(posedge Clk); #1;
      chk("rr_memen", bus.MemEn, (c % 3) == 0);
      chk("rr_gnt", {bus.Gnt1, bus.Gnt0}, (c % 3 == 2) ? 2'b00 : (w == 1 ? 2'b10 : 2'b01));
      chk("rr_done", {bus.Done1, bus.Done0},
          (c % 3 == 1) ? (w == 1 ? 2'b10 : 2'b01) : 2'b00);
      if (c % 3 == 2) begin
        exp_last = w;
        w = 1 - w;
      end
      if (c == 11) begin bus.Req0 = 1'b0; bus.Req1 = 1'b0; end
    end
    sc_mem[4] = 8'h44; sc_mem[5] = 8'h55;

    // Randomized transactions against the reference model
    for (int n = 0; n < 40; n++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      begin
        logic rw0, rw1; logic [3:0] a0, a1; logic [7:0] d0, d1; int t0, t1;
        rw0 = 1'($urandom_range(0, 1)); rw1 = 1'($urandom_range(0, 1));
        a0 = 4'($urandom); a1 = 4'($urandom); d0 = 8'($urandom); d1 = 8'($urandom);
        t0 = int'($urandom_range(0, 11)) - 1;
        t1 = int'($urandom_range(0, 11)) - 1;
        predict(r0, r1, rw0, rw1, t0, t1, port, lat, err);
        run_txn(r0, r1, rw0, rw1, a0, a1, d0, d1, t0, t1, port, lat, err);
      end
    end

    // Reset in the middle of TX: outputs clear at once, no Done, port 0 wins next tie.
    @(negedge Clk);
    bus.Req0 = 1'b1; bus.RW0 = 1'b0; bus.Addr0 = 4'h3;
    @(posedge Clk); #1;
    bus.Req0 = 1'b0;
    repeat (4) @(posedge Clk);
    #1 chk("pre_reset_busy", {bus.Busy, bus.Gnt0}, 2'b11);
    #2 Reset = 1'b1;
    #1 chk_all_zero("async_reset");
    begin
      int seen_done;
      seen_done = 0;
      repeat (2) begin
        @(posedge Clk); #1;
        if (bus.Done0 || bus.Done1) seen_done++;
      end
      chk("reset_no_done", seen_done, 0);
    end
    model_reset();
    @(negedge Clk) Reset = 1'b0;
    run_txn(1'b1, 1'b1, 1'b1, 1'b1, 4'h8, 4'h9, 8'h88, 8'h99, -1, -1, 0, 1, 1'b0);
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 4'h8, 4'h9, 8'h00, 8'h00, 2, -1, 1, 5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
